// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM states, microsecond timing
// windows and small decode helpers.
package ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StRepeatMark
  } ir_state_e;

  // All windows are inclusive and expressed in microseconds.
  localparam logic [15:0] LeadMarkMin  = 16'd8000;
  localparam logic [15:0] LeadMarkMax  = 16'd10000;
  localparam logic [15:0] DataSpaceMin = 16'd3500;
  localparam logic [15:0] DataSpaceMax = 16'd5500;
  localparam logic [15:0] RptSpaceMin  = 16'd1750;
  localparam logic [15:0] RptSpaceMax  = 16'd2750;
  localparam logic [15:0] BitMarkMin   = 16'd300;
  localparam logic [15:0] BitMarkMax   = 16'd800;
  localparam logic [15:0] ZeroSpaceMin = 16'd300;
  localparam logic [15:0] ZeroSpaceMax = 16'd800;
  localparam logic [15:0] OneSpaceMin  = 16'd1200;
  localparam logic [15:0] OneSpaceMax  = 16'd2200;

  function automatic logic in_window(input logic [15:0] dur, input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (dur >= lo) && (dur <= hi);
  endfunction

  function automatic logic inverse_ok(input logic [7:0] upper, input logic [7:0] lower);
    return upper == ~lower;
  endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the raw IR line followed by a rise/fall detector.
// All flops reset high so an idle line produces no spurious edge on release.
module ir_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: measures each synchronized level in microseconds and
// walks leader / 32 data bits / stop (or repeat) with one-cycle result pulses.
module ir_nec_receiver
  import ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter bit          CHECK_INVERSE = 1'b1,
  parameter int unsigned TIMEOUT_US    = 12000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_rx,
  output logic [31:0] ir_command,
  output logic        ir_data_ready,
  output logic        ir_repeat,
  output logic        ir_error
);

  localparam int unsigned PrescaleTc = CLK_FREQ_HZ / 1000000 - 1;
  localparam int unsigned PrescaleW  = (PrescaleTc > 0) ? $clog2(PrescaleTc + 1) : 1;
  localparam logic [PrescaleW-1:0] PrescaleTcW = PrescaleW'(PrescaleTc);
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_US);

  logic rise, fall, lvl_edge;

  ir_sync_edge u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (ir_rx),
    .rise     (rise),
    .fall     (fall)
  );

  assign lvl_edge = rise | fall;

  ir_state_e              state_q, state_d;
  logic [PrescaleW-1:0]   pre_q, pre_d, pre_base;
  logic [15:0]            dur_q, dur_d, dur_base;
  logic [31:0]            shift_q, shift_d;
  logic [31:0]            cmd_q, cmd_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   rdy_q, rdy_d, rep_q, rep_d, err_q, err_d;
  logic                   bad;
  logic                   mark_ok, zero_ok, one_ok;

  // The edge cycle itself is the first cycle of the new level, so the
  // counters restart from zero and then count that cycle.
  always_comb begin
    pre_base = lvl_edge ? '0 : pre_q;
    dur_base = lvl_edge ? '0 : dur_q;
    if (pre_base == PrescaleTcW) begin
      pre_d = '0;
      dur_d = (dur_base == 16'hFFFF) ? dur_base : dur_base + 16'd1;
    end else begin
      pre_d = pre_base + PrescaleW'(1);
      dur_d = dur_base;
    end
  end

  assign mark_ok = in_window(dur_q, BitMarkMin, BitMarkMax);
  assign zero_ok = in_window(dur_q, ZeroSpaceMin, ZeroSpaceMax);
  assign one_ok  = in_window(dur_q, OneSpaceMin, OneSpaceMax);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdy_d   = 1'b0;
    rep_d   = 1'b0;
    bad     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StLeadMark;
      end
      StLeadMark: begin
        if (rise) begin
          if (in_window(dur_q, LeadMarkMin, LeadMarkMax)) state_d = StLeadSpace;
          else                                             bad     = 1'b1;
        end
      end
      StLeadSpace: begin
        if (fall) begin
          if (in_window(dur_q, DataSpaceMin, DataSpaceMax)) begin
            state_d = StBitMark;
            cnt_d   = '0;
            shift_d = '0;
          end else if (in_window(dur_q, RptSpaceMin, RptSpaceMax)) begin
            state_d = StRepeatMark;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StBitMark: begin
        if (rise) begin
          if (mark_ok) state_d = StBitSpace;
          else         bad     = 1'b1;
        end
      end
      StBitSpace: begin
        if (fall) begin
          if (zero_ok || one_ok) begin
            shift_d = {one_ok, shift_q[31:1]};
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? StStopMark : StBitMark;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StStopMark: begin
        if (rise) begin
          if (mark_ok && (!CHECK_INVERSE || inverse_ok(shift_q[31:24], shift_q[23:16]))) begin
            cmd_d   = shift_q;
            rdy_d   = 1'b1;
            state_d = StIdle;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StRepeatMark: begin
        if (rise) begin
          if (mark_ok) begin
            rep_d   = 1'b1;
            state_d = StIdle;
          end else begin
            bad = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !lvl_edge && dur_q > TimeoutLim) bad = 1'b1;

    // A falling edge that breaks a frame may itself start the next leader.
    if (bad) begin
      state_d = fall ? StLeadMark : StIdle;
      shift_d = '0;
      cnt_d   = '0;
    end

    // Glitchy input could fail on back-to-back cycles; keep pulses isolated.
    err_d = bad & ~(err_q | rdy_q | rep_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pre_q   <= '0;
      dur_q   <= '0;
      shift_q <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      shift_q <= shift_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  assign ir_command    = cmd_q;
  assign ir_data_ready = rdy_q;
  assign ir_repeat     = rep_q;
  assign ir_error      = err_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Self-checking bench: two receivers (inverse check on/off) share one IR line
// driven with randomized NEC timing; outcomes come from a frame-level model.
module tb_ir_nec_receiver;

  localparam int unsigned ClkHz = 1000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ir_rx;
  logic [31:0] cmd0, cmd1;
  logic [1:0]  rdy, rep, err;

  ir_nec_receiver #(
    .CLK_FREQ_HZ   (ClkHz),
    .CHECK_INVERSE (1'b1),
    .TIMEOUT_US    (12000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_rx         (ir_rx),
    .ir_command    (cmd0),
    .ir_data_ready (rdy[0]),
    .ir_repeat     (rep[0]),
    .ir_error      (err[0])
  );

  ir_nec_receiver #(
    .CLK_FREQ_HZ   (ClkHz),
    .CHECK_INVERSE (1'b0),
    .TIMEOUT_US    (12000)
  ) dut_noinv (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_rx         (ir_rx),
    .ir_command    (cmd1),
    .ir_data_ready (rdy[1]),
    .ir_repeat     (rep[1]),
    .ir_error      (err[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         n_rdy[2]  = '{0, 0};
  int         n_rep[2]  = '{0, 0};
  int         n_err[2]  = '{0, 0};
  int         rdy_at[2] = '{0, 0};
  int         rep_at[2] = '{0, 0};
  int         n_viol    = 0;
  logic [1:0] rdy_p = '0, rep_p = '0, err_p = '0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy[d]) begin
        n_rdy[d]  <= n_rdy[d] + 1;
        rdy_at[d] <= cyc;
      end
      if (rep[d]) begin
        n_rep[d]  <= n_rep[d] + 1;
        rep_at[d] <= cyc;
      end
      if (err[d]) n_err[d] <= n_err[d] + 1;
      if ((int'(rdy[d]) + int'(rep[d]) + int'(err[d]) > 1) ||
          (rdy[d] && rdy_p[d]) || (rep[d] && rep_p[d]) || (err[d] && err_p[d]))
        n_viol <= n_viol + 1;
    end
    rdy_p <= rdy;
    rep_p <= rep;
    err_p <= err;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame acceptance from the NEC inverse-byte rule.
  logic [31:0] exp_cmd[2];

  function automatic bit accepts(input logic [31:0] f, input int d);
    return (d == 1) || (f[31:24] == ~f[23:16]);
  endfunction

  function automatic int urange(input int lo, input int hi);
    return lo + int'($urandom_range(32'(hi - lo)));
  endfunction

  function automatic logic [31:0] valid_word();
    logic [31:0] r;
    r = $urandom;
    return {~r[7:0], r[7:0], r[31:16]};
  endfunction

  // Level list: 0 leader mark, 1 leader space, 2+2i bit mark, 3+2i bit space, 66 stop.
  int lv[67];
  int rise_at;
  int b_rdy[2], b_rep[2], b_err[2];

  task automatic build(input logic [31:0] data, input bit nominal);
    lv[0] = nominal ? 9000 : urange(8000, 8600);
    lv[1] = nominal ? 4500 : urange(3500, 3900);
    for (int i = 0; i < 32; i++) begin
      lv[2 + 2 * i] = nominal ? 560 : urange(300, 800);
      if (data[i]) lv[3 + 2 * i] = nominal ? 1690 : urange(1200, 1500);
      else         lv[3 + 2 * i] = nominal ? 560 : urange(300, 800);
    end
    lv[66] = nominal ? 560 : urange(300, 800);
  endtask

  task automatic drive(input logic v, input int us);
    ir_rx = v;
    repeat (us) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play(input int last);
    for (int i = 0; i <= last; i++) drive(i % 2 == 1, lv[i]);
    ir_rx   = 1'b1;
    rise_at = cyc;
  endtask

  task automatic send_repeat();
    drive(1'b0, 9000);
    drive(1'b1, 2250);
    drive(1'b0, 560);
    ir_rx   = 1'b1;
    rise_at = cyc;
  endtask

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      b_rdy[d] = n_rdy[d];
      b_rep[d] = n_rep[d];
      b_err[d] = n_err[d];
    end
  endtask

  task automatic expect_out(input string tag, input int d, input int e_rdy, input int e_rep,
                            input int e_err);
    check_val($sformatf("%s.d%0d.rdy", tag, d), 32'(n_rdy[d] - b_rdy[d]), 32'(e_rdy));
    check_val($sformatf("%s.d%0d.rep", tag, d), 32'(n_rep[d] - b_rep[d]), 32'(e_rep));
    check_val($sformatf("%s.d%0d.err", tag, d), 32'(n_err[d] - b_err[d]), 32'(e_err));
    check_val($sformatf("%s.d%0d.cmd", tag, d), (d == 0) ? cmd0 : cmd1, exp_cmd[d]);
    if (e_rdy > 0 && n_rdy[d] > b_rdy[d])
      check_val($sformatf("%s.d%0d.rdy_lat", tag, d), 32'(rdy_at[d] - rise_at), 32'd3);
    if (e_rep > 0 && n_rep[d] > b_rep[d])
      check_val($sformatf("%s.d%0d.rep_lat", tag, d), 32'(rep_at[d] - rise_at), 32'd3);
  endtask

  task automatic frame_txn(input string tag, input logic [31:0] data);
    bit acc;
    snap();
    play(66);
    drive(1'b1, 40);
    for (int d = 0; d < 2; d++) begin
      acc = accepts(data, d);
      if (acc) exp_cmd[d] = data;
      expect_out(tag, d, int'(acc), 0, int'(!acc));
    end
  endtask

  task automatic bad_txn(input string tag, input int last);
    snap();
    play(last);
    drive(1'b1, 40);
    for (int d = 0; d < 2; d++) expect_out(tag, d, 0, 0, 1);
  endtask

  initial begin
    logic [31:0] w;
    ir_rx      = 1'b1;
    reset_n    = 1'b0;
    exp_cmd[0] = '0;
    exp_cmd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.cmd0", cmd0, 32'h0);
    check_val("rst.cmd1", cmd1, 32'h0);
    check_val("rst.pulses", {26'h0, rdy, rep, err}, 32'h0);
    reset_n = 1'b1;
    drive(1'b1, 20);

    build(32'hED126B86, 1'b1);
    frame_txn("power", 32'hED126B86);

    build(32'hE51A6B86, 1'b0);
    frame_txn("pre_rpt", 32'hE51A6B86);
    snap();
    send_repeat();
    drive(1'b1, 40);
    for (int d = 0; d < 2; d++) expect_out("repeat", d, 0, 1, 0);

    build(32'hEE126B86, 1'b0);
    frame_txn("bad_inv", 32'hEE126B86);

    // Bit 10 space stretched to 3000 us; its closing fall starts the next leader.
    build(valid_word(), 1'b0);
    lv[23] = 3000;
    snap();
    play(23);
    build(32'hE11E6B86, 1'b0);
    play(66);
    drive(1'b1, 40);
    for (int d = 0; d < 2; d++) begin
      exp_cmd[d] = 32'hE11E6B86;
      expect_out("stretch", d, 1, 0, 1);
    end

    // Reset mid-frame during the bit 20 mark.
    build(32'hE9166B86, 1'b0);
    snap();
    play(41);
    drive(1'b0, 200);
    reset_n = 1'b0;
    ir_rx   = 1'b1;
    drive(1'b1, 10);
    reset_n = 1'b1;
    drive(1'b1, 40);
    for (int d = 0; d < 2; d++) begin
      exp_cmd[d] = '0;
      expect_out("midrst", d, 0, 0, 0);
    end
    frame_txn("post_rst", 32'hE9166B86);

    w = valid_word();
    build(w, 1'b0);
    lv[2]  = 800;
    lv[4]  = 300;
    lv[66] = 300;
    frame_txn("edges_ok", w);

    build(valid_word(), 1'b0);
    lv[2] = 299;
    bad_txn("mark299", 2);

    build(valid_word(), 1'b0);
    lv[2] = 801;
    bad_txn("mark801", 2);

    build(valid_word(), 1'b0);
    lv[2] = 13000;
    bad_txn("timeout", 2);

    for (int k = 0; k < 2; k++) begin
      w = ($urandom_range(1) == 1) ? valid_word() : $urandom;
      build(w, 1'b0);
      frame_txn($sformatf("rand%0d", k), w);
    end

    check_val("pulse_excl", 32'(n_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
